hpdcache_refill_data_adapter: RTL and testbench
===============================================

// Module: hpdcache_refill_data_adapter
// PURPOSE
//  Upsizes memory-response data beats into ACCESS_WORDS-wide refill chunks for the HPDcache data array.
//  Sits between the memory read-response interface and the refill handler's data-RAM write port.
//  Tracks the chunk index within the cache line, the response ID and sticky error per line.
//  Flags protocol violations: early or missing last, and ID change inside a line.
// PARAMETERS
//  WORD_WIDTH      64  cache word width (bits), = PARAM_WORD_WIDTH
//  CL_WORDS        8   words per cache line, = PARAM_CL_WORDS
//  ACCESS_WORDS    4   words written per refill chunk, = PARAM_ACCESS_WORDS; divides CL_WORDS
//  MEM_DATA_WIDTH  64  memory beat width; divides ACCESS_WORDS*WORD_WIDTH
//  MEM_ID_WIDTH    4   memory response ID width
//  Derived: AW = ACCESS_WORDS*WORD_WIDTH; R = AW/MEM_DATA_WIDTH beats/chunk; C = CL_WORDS/ACCESS_WORDS chunks/line
// PORTS
//  clk_i            in   1             clock
//  rst_i            in   1             asynchronous reset, active-high
//  mem_rsp_valid_i  in   1             response beat valid
//  mem_rsp_ready_o  out  1             beat accepted when valid&ready
//  mem_rsp_data_i   in   MEM_DATA_WIDTH beat data
//  mem_rsp_id_i     in   MEM_ID_WIDTH  response ID
//  mem_rsp_error_i  in   1             beat error
//  mem_rsp_last_i   in   1             final beat of cache line
//  refill_valid_o   out  1             chunk valid
//  refill_ready_i   in   1             chunk consumed when valid&ready
//  refill_data_o    out  AW            chunk data, beat k in bits [k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH]
//  refill_word_o    out  $clog2(CL_WORDS) first word index of chunk = chunk_cnt*ACCESS_WORDS
//  refill_id_o      out  MEM_ID_WIDTH  ID latched from first beat of line
//  refill_error_o   out  1             sticky OR of all beat errors of line so far, incl. protocol errors
//  refill_last_o    out  1             chunk is final chunk of line
//  protocol_err_o   out  1             one-cycle pulse on protocol violation
// BEHAVIOUR
//  - Reset: all outputs 0 except mem_rsp_ready_o=1; beat_cnt, chunk_cnt, sticky error, data reg cleared.
//  - Reset mid-line: partial chunk and line state discarded; next beat is treated as beat 0 of a new line.
//  - Single output register doubles as accumulator. mem_rsp_ready_o = !refill_valid_o | refill_ready_i (combinational).
//  - Accepted beat writes lane beat_cnt; beat_cnt++ mod R. On beat_cnt==R-1, or mem_rsp_last_i: refill_valid_o=1 next cycle.
//  - Latency: chunk valid the cycle after its last beat is accepted. R=1 with refill_ready_i=1 sustains one chunk/cycle.
//  - refill_valid_o, data, word, id, error, last stay stable while valid & !ready.
//  - Drain: on valid&ready with no chunk-completing beat, valid drops; a beat accepted in the same cycle starts the next chunk (lanes of the drained chunk are not zeroed except on early last, see below).
//  - chunk_cnt increments on each emitted chunk; wraps to 0 after the chunk flagged last.
//  - refill_last_o = 1 when the emitted chunk is chunk C-1 or closes on mem_rsp_last_i.
//  - First beat of line (beat_cnt==0 & chunk_cnt==0): latch id, sticky error := mem_rsp_error_i.
//  - Later beats: sticky error |= mem_rsp_error_i; id differs from latched -> protocol_err_o pulse, sticky error=1.
//  - Early last (last on beat before final beat of line): chunk emitted with unfilled lanes zeroed, refill_last_o=1,
//    refill_error_o=1, protocol_err_o pulse; counters reset for next line.
//  - Missing last (final beat of line without mem_rsp_last_i): chunk emitted with refill_last_o=1, error=1,
//    protocol_err_o pulse; following beat starts new line.
//  - protocol_err_o asserted exactly one cycle after the offending beat is accepted.
//  - Beats with valid=0 never modify state; ready may toggle freely.
// TESTING
//  - R=4,C=2: 8 beats D0..D7 id=3, last on D7, ready=1 -> chunk {D3..D0} word=0 last=0, chunk {D7..D4} word=4 last=1, id=3, err=0.
//  - refill_ready_i=0 for 5 cycles after chunk0 -> mem_rsp_ready_o=0 after beat 3 stalls; chunk0 fields stable; no beat lost.
//  - mem_rsp_error_i=1 on beat 2 only -> chunk0 error=1 and chunk1 error=1; protocol_err_o stays 0.
//  - last on beat 5 -> chunk1 = {0,0,D5,D4}, word=4, last=1, error=1, protocol_err_o 1-cycle pulse; next line starts at word 0.
//  - id 3 then id 5 on beat 1 -> protocol_err_o pulse, error=1 on both chunks, refill_id_o=3.
//  - rst_i asserted after beat 2 -> refill_valid_o=0 immediately; next 8 beats produce words 0 and 4 normally.

Source files
------------

// File: rtl/hpdcache_refill_data_adapter.sv
// rtl/hpdcache_refill_data_adapter.sv - upsizes memory response beats into refill chunks
module hpdcache_refill_data_adapter #(
    parameter int WORD_WIDTH     = 64,
    parameter int CL_WORDS       = 8,
    parameter int ACCESS_WORDS   = 4,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int MEM_ID_WIDTH   = 4,
    localparam int AW = ACCESS_WORDS * WORD_WIDTH,
    localparam int WW = $clog2(CL_WORDS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mem_rsp_valid_i,
    output logic                      mem_rsp_ready_o,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data_i,
    input  logic [MEM_ID_WIDTH-1:0]   mem_rsp_id_i,
    input  logic                      mem_rsp_error_i,
    input  logic                      mem_rsp_last_i,
    output logic                      refill_valid_o,
    input  logic                      refill_ready_i,
    output logic [AW-1:0]             refill_data_o,
    output logic [WW-1:0]             refill_word_o,
    output logic [MEM_ID_WIDTH-1:0]   refill_id_o,
    output logic                      refill_error_o,
    output logic                      refill_last_o,
    output logic                      protocol_err_o
);
    localparam int R  = AW / MEM_DATA_WIDTH;
    localparam int C  = CL_WORDS / ACCESS_WORDS;
    localparam int BW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam logic [BW-1:0] BEAT_MAX  = BW'(R - 1);
    localparam logic [CW-1:0] CHUNK_MAX = CW'(C - 1);

    logic [AW-1:0]           data_q, data_d;
    logic                    valid_q, valid_d;
    logic [WW-1:0]           word_q, word_d;
    logic                    error_q, error_d;
    logic                    last_q, last_d;
    logic [MEM_ID_WIDTH-1:0] id_q, id_d;
    logic                    sticky_q, sticky_d;
    logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]           chunk_cnt_q, chunk_cnt_d;
    logic                    perr_q, perr_d;

    logic accept, first_beat, final_beat, id_mismatch, early_last, missing_last;
    logic chunk_done, line_end, line_error;

    // The output register is also the accumulator, so beats are only taken once it is free or draining.
    assign mem_rsp_ready_o = !valid_q | refill_ready_i;
    assign accept          = mem_rsp_valid_i & mem_rsp_ready_o;
    assign first_beat      = (beat_cnt_q == '0) && (chunk_cnt_q == '0);
    assign final_beat      = (beat_cnt_q == BEAT_MAX) && (chunk_cnt_q == CHUNK_MAX);
    assign id_mismatch     = !first_beat && (mem_rsp_id_i != id_q);
    assign early_last      = mem_rsp_last_i && !final_beat;
    assign missing_last    = final_beat && !mem_rsp_last_i;
    assign chunk_done      = (beat_cnt_q == BEAT_MAX) || mem_rsp_last_i;
    assign line_end        = final_beat || mem_rsp_last_i;
    assign line_error      = (first_beat ? mem_rsp_error_i : (sticky_q | mem_rsp_error_i))
                             | id_mismatch | early_last | missing_last;

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        word_d      = word_q;
        error_d     = error_q;
        last_d      = last_q;
        id_d        = id_q;
        sticky_d    = sticky_q;
        beat_cnt_d  = beat_cnt_q;
        chunk_cnt_d = chunk_cnt_q;
        perr_d      = 1'b0;
        if (valid_q && refill_ready_i) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            // Lanes above the current beat are cleared only when the line closes early.
            for (int k = 0; k < R; k++) begin
                if (BW'(k) == beat_cnt_q) begin
                    data_d[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rsp_data_i;
                end else if (early_last && (BW'(k) > beat_cnt_q)) begin
                    data_d[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = '0;
                end
            end
            sticky_d = line_error;
            perr_d   = id_mismatch | early_last | missing_last;
            if (first_beat) begin
                id_d = mem_rsp_id_i;
            end
            if (chunk_done) begin
                valid_d     = 1'b1;
                word_d      = WW'(chunk_cnt_q) * WW'(ACCESS_WORDS);
                error_d     = line_error;
                last_d      = line_end;
                beat_cnt_d  = '0;
                chunk_cnt_d = line_end ? '0 : chunk_cnt_q + CW'(1);
            end else begin
                beat_cnt_d = beat_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            word_q      <= '0;
            error_q     <= 1'b0;
            last_q      <= 1'b0;
            id_q        <= '0;
            sticky_q    <= 1'b0;
            beat_cnt_q  <= '0;
            chunk_cnt_q <= '0;
            perr_q      <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            word_q      <= word_d;
            error_q     <= error_d;
            last_q      <= last_d;
            id_q        <= id_d;
            sticky_q    <= sticky_d;
            beat_cnt_q  <= beat_cnt_d;
            chunk_cnt_q <= chunk_cnt_d;
            perr_q      <= perr_d;
        end
    end

    assign refill_valid_o = valid_q;
    assign refill_data_o  = data_q;
    assign refill_word_o  = word_q;
    assign refill_id_o    = id_q;
    assign refill_error_o = error_q;
    assign refill_last_o  = last_q;
    assign protocol_err_o = perr_q;
endmodule

// File: tb/tb_hpdcache_refill_data_adapter.sv
// tb/tb_hpdcache_refill_data_adapter.sv - bench for hpdcache_refill_data_adapter
module tb_hpdcache_refill_data_adapter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_rsp_valid_i = 1'b0;
    logic         mem_rsp_ready_o;
    logic [63:0]  mem_rsp_data_i = '0;
    logic [3:0]   mem_rsp_id_i = '0;
    logic         mem_rsp_error_i = 1'b0;
    logic         mem_rsp_last_i = 1'b0;
    logic         refill_valid_o;
    logic         refill_ready_i = 1'b1;
    logic [255:0] refill_data_o;
    logic [2:0]   refill_word_o;
    logic [3:0]   refill_id_o;
    logic         refill_error_o;
    logic         refill_last_o;
    logic         protocol_err_o;

    hpdcache_refill_data_adapter dut (
        .clk_i(clk), .rst_i(rst),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_id_i(mem_rsp_id_i),
        .mem_rsp_error_i(mem_rsp_error_i), .mem_rsp_last_i(mem_rsp_last_i),
        .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
        .refill_data_o(refill_data_o), .refill_word_o(refill_word_o),
        .refill_id_o(refill_id_o), .refill_error_o(refill_error_o),
        .refill_last_o(refill_last_o), .protocol_err_o(protocol_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [2:0]   word;
        logic [3:0]   id;
        logic         err;
        logic         last;
    } exp_t;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  id;
        logic        err;
        logic        last;
        logic        perr;
        logic        emit;
        exp_t        ex;
    } vec_t;

    vec_t tab[$];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [63:0] dv(input int s, input int k);
        return {16'hC0DE, 16'(s), 32'(k)};
    endfunction

    function automatic logic [255:0] ch(input int s, input int start, input int nl);
        logic [255:0] r = '0;
        for (int i = 0; i < nl; i++) r[i*64 +: 64] = dv(s, start + i);
        return r;
    endfunction

    function automatic void add(input int s, input int k, input int id, input logic err,
                                input logic last, input logic perr);
        vec_t v;
        v.d = dv(s, k); v.id = 4'(id); v.err = err; v.last = last; v.perr = perr; v.emit = 1'b0;
        v.ex = '{data: '0, word: '0, id: '0, err: 1'b0, last: 1'b0};
        tab.push_back(v);
    endfunction

    function automatic void adde(input int s, input int k, input int id, input logic err,
                                 input logic last, input logic perr, input logic [255:0] edata,
                                 input int word, input int eid, input logic eerr, input logic elast);
        vec_t v;
        v.d = dv(s, k); v.id = 4'(id); v.err = err; v.last = last; v.perr = perr; v.emit = 1'b1;
        v.ex = '{data: edata, word: 3'(word), id: 4'(eid), err: eerr, last: elast};
        tab.push_back(v);
    endfunction

    function automatic void normal(input int s, input int id);
        for (int k = 0; k < 8; k++) begin
            if (k == 3)      adde(s, k, id, 0, 0, 0, ch(s, 0, 4), 0, id, 0, 0);
            else if (k == 7) adde(s, k, id, 0, 1, 0, ch(s, 4, 4), 4, id, 0, 1);
            else             add(s, k, id, 0, 0, 0);
        end
    endfunction

    // Applies the beat table; refill_ready_i is low for cycles [st, st+sl) of the run.
    task automatic run(input int st, input int sl);
        int   idx = 0;
        int   cyc = 0;
        logic pend = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            chk("perr_pulse", protocol_err_o, pend);
            pend = 1'b0;
            if (idx >= tab.size()) mem_rsp_valid_i = 1'b0;
            if (idx >= tab.size() && sb.size() == 0 && !refill_valid_o) break;
            if (cyc >= 300) begin
                n_total++;
                $display("FAIL timeout beats_left=%0d chunks_left=%0d", tab.size() - idx, sb.size());
                mem_rsp_valid_i = 1'b0;
                break;
            end
            refill_ready_i = !(cyc >= st && cyc < st + sl);
            if (idx < tab.size()) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = tab[idx].d;
                mem_rsp_id_i    = tab[idx].id;
                mem_rsp_error_i = tab[idx].err;
                mem_rsp_last_i  = tab[idx].last;
            end
            #1;
            if (refill_valid_o) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_chunk actual word=%0d required no chunk", refill_word_o);
                end else begin
                    e = refill_ready_i ? sb.pop_front() : sb[0];
                    chk("data", refill_data_o, e.data);
                    chk("word", refill_word_o, e.word);
                    chk("id", refill_id_o, e.id);
                    chk("error", refill_error_o, e.err);
                    chk("last", refill_last_o, e.last);
                    if (!refill_ready_i) chk("stall_ready", mem_rsp_ready_o, 1'b0);
                end
            end
            if (mem_rsp_valid_i && mem_rsp_ready_o) begin
                if (tab[idx].emit) sb.push_back(tab[idx].ex);
                pend = tab[idx].perr;
                idx++;
            end
            cyc++;
        end
        tab.delete();
        sb.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", refill_valid_o, 1'b0);
        chk("rst_ready", mem_rsp_ready_o, 1'b1);
        chk("rst_data", refill_data_o, '0);
        chk("rst_word", refill_word_o, '0);
        chk("rst_id", refill_id_o, '0);
        chk("rst_error", refill_error_o, 1'b0);
        chk("rst_last", refill_last_o, 1'b0);
        chk("rst_perr", protocol_err_o, 1'b0);
        rst = 1'b0;

        normal(1, 3);
        run(1000, 0);

        normal(2, 3);
        run(4, 5);

        for (int k = 0; k < 8; k++) begin
            if (k == 3)      adde(3, k, 3, 0, 0, 0, ch(3, 0, 4), 0, 3, 1, 0);
            else if (k == 7) adde(3, k, 3, 0, 1, 0, ch(3, 4, 4), 4, 3, 1, 1);
            else             add(3, k, 3, (k == 2), 0, 0);
        end
        run(1000, 0);

        normal(5, 7);
        add(6, 0, 2, 0, 0, 0);
        adde(6, 1, 2, 0, 1, 1, ch(6, 0, 2), 0, 2, 1, 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 3) adde(4, k, 3, 0, 0, 0, ch(4, 0, 4), 0, 3, 0, 0);
            else        add(4, k, 3, 0, 0, 0);
        end
        adde(4, 5, 3, 0, 1, 1, ch(4, 4, 2), 4, 3, 1, 1);
        normal(16, 1);
        run(1000, 0);

        for (int k = 0; k < 8; k++) begin
            if (k == 3)      adde(11, k, 3, 0, 0, 0, ch(11, 0, 4), 0, 3, 1, 0);
            else if (k == 7) adde(11, k, 3, 0, 1, 0, ch(11, 4, 4), 4, 3, 1, 1);
            else             add(11, k, (k == 1) ? 5 : 3, 0, 0, (k == 1));
        end
        run(1000, 0);

        for (int k = 0; k < 8; k++) begin
            if (k == 3)      adde(12, k, 4, 0, 0, 0, ch(12, 0, 4), 0, 4, 0, 0);
            else if (k == 7) adde(12, k, 4, 0, 0, 1, ch(12, 4, 4), 4, 4, 1, 1);
            else             add(12, k, 4, 0, 0, 0);
        end
        normal(13, 6);
        run(1000, 0);

        for (int k = 0; k < 3; k++) add(14, k, 9, 0, 0, 0);
        run(1000, 0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = dv(14, 3);
        mem_rsp_id_i    = 4'd9;
        mem_rsp_last_i  = 1'b0;
        refill_ready_i  = 1'b0;
        @(posedge clk);
        #1 mem_rsp_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", refill_valid_o, 1'b1);
        chk("pre_rst_ready", mem_rsp_ready_o, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", refill_valid_o, 1'b0);
        chk("mid_rst_ready", mem_rsp_ready_o, 1'b1);
        chk("mid_rst_perr", protocol_err_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        refill_ready_i = 1'b1;
        normal(15, 3);
        run(1000, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
